// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the BCD score sequencer.
// Saturation mode is selected at build time with SCORE_SATURATE_EN (see top).
package score_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam logic [3:0]  BCD_MAX    = 4'd9;
   localparam logic [3:0]  AMOUNT_MAX = 4'd9;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   // Non-decimal request codes are treated as the largest legal amount.
   function automatic logic [3:0] clamp_amount(input logic [3:0] amount);
      return (amount > AMOUNT_MAX) ? AMOUNT_MAX : amount;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the score: 0..9 counter with sync clear, enable-in and
// a carry-out that fires when the digit rolls over from 9.
module bcd_digit
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en_in,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry_out
);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (en_in) begin
         digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + DIGIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = en_in && (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_score_sequencer.sv
// Adds a requested number of points to a packed BCD score, one point per
// enabled cycle. Define SCORE_SATURATE_EN to hold at all-nines instead of wrapping.
module bcd_score_sequencer
   import score_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Ena,
   input  logic                      Clear,
   input  logic                      Req,
   input  logic [3:0]                Amount,
   output logic                      Ack,
   output logic                      Busy,
   output logic                      Step,
   output logic                      Overflow,
   output logic [DIGIT_W*DIGITS-1:0] Score
);

   // Handshake: Req is a level held by the requester; it is sampled only
   // while Busy=0 and Clear=0, and Ack pulses for one cycle after the
   // accepting edge. The requester drops Req once it sees Ack.

   state_e     state_q, state_d;
   logic [3:0] remaining_q, remaining_d;
   logic       ack_q, ack_d;
   logic       step_q, step_d;
   logic       overflow_q, overflow_d;
   logic       inc_en;
   logic [DIGITS:0] carry;
   logic [3:0] amount_clamped;

   assign amount_clamped = clamp_amount(Amount);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (Clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (Req && (amount_clamped != 4'd0)) state_d = ST_COUNT;
            ST_COUNT: if (Ena && (remaining_q == 4'd1))    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ack_d       = 1'b0;
      step_d      = 1'b0;
      remaining_d = remaining_q;
      if (Clear) begin
         remaining_d = 4'd0;
      end else if ((state_q == ST_IDLE) && Req) begin
         ack_d       = 1'b1;
         remaining_d = amount_clamped;
      end else if ((state_q == ST_COUNT) && Ena) begin
         step_d      = 1'b1;
         remaining_d = remaining_q - 4'd1;
      end
   end

`ifdef SCORE_SATURATE_EN
   logic all_nines;

   always_comb begin
      all_nines = 1'b1;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (Score[k*DIGIT_W +: DIGIT_W] != BCD_MAX) all_nines = 1'b0;
      end
   end

   // At all-nines the step is still taken but the digit chain is not advanced.
   assign inc_en     = step_d && !all_nines;
   assign overflow_d = step_d && all_nines;
`else
   // Carry out of the top digit is exactly a step taken at all-nines.
   assign inc_en     = step_d;
   assign overflow_d = carry[DIGITS];
`endif

   assign carry[0] = inc_en;

   for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
      bcd_digit u_digit (
         .clk       (Clk),
         .rst       (Reset),
         .clr       (Clear),
         .en_in     (carry[k]),
         .digit     (Score[k*DIGIT_W +: DIGIT_W]),
         .carry_out (carry[k+1])
      );
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         remaining_q <= 4'd0;
         ack_q       <= 1'b0;
         step_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         remaining_q <= remaining_d;
         ack_q       <= ack_d;
         step_q      <= step_d;
         overflow_q  <= overflow_d;
      end
   end

   assign Busy     = (state_q == ST_COUNT);
   assign Ack      = ack_q;
   assign Step     = step_q;
   assign Overflow = overflow_q;

endmodule

// File: tb/tb_bcd_score_sequencer.sv
// Bench for bcd_score_sequencer: directed scenarios then random traffic,
// all checked against an integer-valued score model.
module tb_bcd_score_sequencer;

   localparam int DIGITS = 4;
   localparam int MAXV   = 9999;

   logic                  Clk = 1'b0;
   logic                  Reset = 1'b1;
   logic                  Ena = 1'b0;
   logic                  Clear = 1'b0;
   logic                  Req = 1'b0;
   logic [3:0]            Amount = 4'd0;
   logic                  Ack, Busy, Step, Overflow;
   logic [4*DIGITS-1:0]   Score;

   always #5 Clk = ~Clk;

   bcd_score_sequencer #(.DIGITS(DIGITS)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Ena      (Ena),
      .Clear    (Clear),
      .Req      (Req),
      .Amount   (Amount),
      .Ack      (Ack),
      .Busy     (Busy),
      .Step     (Step),
      .Overflow (Overflow),
      .Score    (Score)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: score as a plain integer, pending points as a count.
   int m_score = 0;
   int m_rem   = 0;
   bit m_busy  = 1'b0;
   bit m_ack   = 1'b0;
   bit m_step  = 1'b0;
   bit m_ovf   = 1'b0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++) begin
         r[k*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic model_edge(input bit rst, input bit ena, input bit clr, input bit req, input int amt);
      m_ack  = 1'b0;
      m_step = 1'b0;
      m_ovf  = 1'b0;
      if (rst || clr) begin
         m_score = 0;
         m_rem   = 0;
         m_busy  = 1'b0;
      end else if (!m_busy) begin
         if (req) begin
            m_ack  = 1'b1;
            m_rem  = (amt > 9) ? 9 : amt;
            m_busy = (m_rem > 0);
         end
      end else if (ena) begin
         m_step = 1'b1;
         if (m_score == MAXV) begin
            m_ovf = 1'b1;
`ifdef SCORE_SATURATE_EN
            m_score = MAXV;
`else
            m_score = 0;
`endif
         end else begin
            m_score = m_score + 1;
         end
         m_rem = m_rem - 1;
         if (m_rem == 0) m_busy = 1'b0;
         exp_q.push_back(to_bcd(m_score));
      end
   endtask

   task automatic tick(input bit rst, input bit ena, input bit clr, input bit req, input logic [3:0] amt);
      Reset  = rst;
      Ena    = ena;
      Clear  = clr;
      Req    = req;
      Amount = amt;
      @(posedge Clk);
      model_edge(rst, ena, clr, req, int'(amt));
      #1;
      chk("ack", {31'd0, Ack}, {31'd0, m_ack});
      chk("busy", {31'd0, Busy}, {31'd0, m_busy});
      chk("step", {31'd0, Step}, {31'd0, m_step});
      chk("overflow", {31'd0, Overflow}, {31'd0, m_ovf});
      chk("score", 32'(Score), to_bcd(m_score));
      if (Step === 1'b1) begin
         if (exp_q.size() == 0) chk("step_unexpected", {31'd0, Step}, 32'd0);
         else chk("step_score", 32'(Score), exp_q.pop_front());
      end
   endtask

   task automatic request(input logic [3:0] amt);
      int guard;
      guard = 0;
      do begin
         tick(1'b0, 1'b1, 1'b0, 1'b1, amt);
         guard++;
      end while (!m_ack && guard < 20);
      if (!m_ack) chk("ack_timeout", {31'd0, Ack}, 32'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (m_busy && guard < 40) begin
         tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
         guard++;
      end
      if (m_busy) chk("busy_timeout", {31'd0, Busy}, 32'd0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic add(input logic [3:0] amt);
      request(amt);
      drain();
   endtask

   task automatic clear_score();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
   endtask

   bit         r_rst, r_clr, r_ena, r_hold;
   logic [3:0] r_amt;

   initial begin
      // Reset, including overriding a simultaneous Clear and Req
      tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      chk("reset_score", 32'(Score), 32'h0);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_ack", {31'd0, Ack}, 32'd0);

      // Basic add of 3
      add(4'd3);
      chk("add3_score", 32'(Score), 32'h0003);

      // Decade carry across 0098 -> 0103
      clear_score();
      repeat (10) add(4'd9);
      add(4'd8);
      chk("pre98_score", 32'(Score), 32'h0098);
      add(4'd5);
      chk("carry_score", 32'(Score), 32'h0103);

      // Top-end wrap or saturate from 9998
      clear_score();
      repeat (1110) add(4'd9);
      add(4'd8);
      chk("pre9998_score", 32'(Score), 32'h9998);
      add(4'd3);
`ifdef SCORE_SATURATE_EN
      chk("top_end_score", 32'(Score), 32'h9999);
`else
      chk("top_end_score", 32'(Score), 32'h0001);
`endif

      // Freeze for two cycles after the first step
      clear_score();
      request(4'd4);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      drain();
      chk("freeze_score", 32'(Score), 32'h0004);

      // Clear on the second COUNT cycle while Req is held
      request(4'd9);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
      chk("clear_score", 32'(Score), 32'h0);
      chk("clear_busy", {31'd0, Busy}, 32'd0);
      chk("clear_ack", {31'd0, Ack}, 32'd0);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
      chk("after_clear_ack", {31'd0, Ack}, 32'd1);
      drain();
      chk("after_clear_score", 32'(Score), 32'h0002);

      // Clamped amount, then zero amount
      clear_score();
      add(4'hC);
      chk("clamp_score", 32'(Score), 32'h0009);
      add(4'd0);
      chk("zero_score", 32'(Score), 32'h0009);
      chk("zero_busy", {31'd0, Busy}, 32'd0);

      // Reset mid-count drops the pending steps
      request(4'd9);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("reset_mid_score", 32'(Score), 32'h0);

      // Random traffic
      r_hold = 1'b0;
      r_amt  = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 299) == 0);
         r_clr = ($urandom_range(0, 24) == 0);
         r_ena = ($urandom_range(0, 3) != 0);
         if (!r_hold && $urandom_range(0, 2) == 0) begin
            r_hold = 1'b1;
            r_amt  = 4'($urandom_range(0, 15));
         end
         tick(r_rst, r_ena, r_clr, r_hold, r_amt);
         if (m_ack) r_hold = 1'b0;
      end

      chk("exp_q_left", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
